// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: client-side and multiplier-side buses of the
// shared-multiplier arbiter. master = arbiter view, slave = environment view.
interface mult_share_arbiter_if #(
    parameter int N    = 8,
    parameter int NREQ = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   cl_req;
    logic [NREQ*N-1:0] cl_sn;
    logic [NREQ*N-1:0] cl_sbn;
    logic [NREQ-1:0]   cl_ack;
    logic [2*N-1:0]    cl_tich;
    logic              cl_err;
    logic              m_req;
    logic [N-1:0]      m_sn;
    logic [N-1:0]      m_sbn;
    logic [2*N-1:0]    m_tich;
    logic              m_ack;
    logic              busy;
    logic [IW-1:0]     grant_id;

    modport master (
        input  cl_req, cl_sn, cl_sbn, m_tich, m_ack,
        output cl_ack, cl_tich, cl_err, m_req,
        output m_sn, m_sbn, busy, grant_id
    );

    modport slave (
        output cl_req, cl_sn, cl_sbn, m_tich, m_ack,
        input  cl_ack, cl_tich, cl_err, m_req,
        input  m_sn, m_sbn, busy, grant_id
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one sequential multiplier.
// Optional WAIT timeout with cl_err enabled by defining MARB_TIMEOUT_EN.
module mult_share_arbiter #(
    parameter int N       = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input logic                clk,
    input logic                rst,
    mult_share_arbiter_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_cfg_chk
        $error("mult_share_arbiter: unsupported parameters");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IW-1:0]  ptr;
    logic [IW-1:0]  grant_q;
    logic [IW-1:0]  pick;
    logic [IW-1:0]  cand;
    logic           found;
    logic           ack_q;
    logic           done;
    logic [N-1:0]   sn_q;
    logic [N-1:0]   sbn_q;
    logic [2*N-1:0] tich_q;

    function automatic logic [IW-1:0] rot(
        input logic [IW-1:0] base,
        input int            k
    );
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // first requester at or above ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rot(ptr, k);
            if (!found && bus.cl_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // a level left high by the previous op must not count
    assign done = bus.m_ack & ~ack_q;

`ifdef MARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wcnt;
    logic          err_q;
    logic          expire;

    assign expire = (state == WAIT) && !done
                  && (wcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE) wcnt <= '0;
            else if (state == WAIT) wcnt <= wcnt + 1'b1;
            if (state == WAIT && done) err_q <= 1'b0;
            else if (expire) err_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (found) state_nx = ISSUE;
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (done) state_nx = RESP;
`ifdef MARB_TIMEOUT_EN
                else if (expire) state_nx = RESP;
`endif
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            ptr     <= '0;
            grant_q <= '0;
            sn_q    <= '0;
            sbn_q   <= '0;
            tich_q  <= '0;
        end else begin
            ack_q <= bus.m_ack;
            if (state == IDLE && found) begin
                grant_q <= pick;
                sn_q    <= bus.cl_sn[int'(pick)*N +: N];
                sbn_q   <= bus.cl_sbn[int'(pick)*N +: N];
            end
            if (state == WAIT && done) tich_q <= bus.m_tich;
`ifdef MARB_TIMEOUT_EN
            else if (expire) tich_q <= '0;
`endif
            if (state == RESP) begin
                if (grant_q == IW'(NREQ - 1)) ptr <= '0;
                else ptr <= grant_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.m_req  = 1'b0;
        bus.cl_ack = '0;
        bus.cl_err = 1'b0;
        bus.busy   = 1'b1;
        case (state)
            IDLE:  bus.busy  = 1'b0;
            ISSUE: bus.m_req = 1'b1;
            RESP: begin
                bus.cl_ack[grant_q] = 1'b1;
`ifdef MARB_TIMEOUT_EN
                bus.cl_err = err_q;
`endif
            end
            default: ;
        endcase
    end

    assign bus.m_sn     = sn_q;
    assign bus.m_sbn    = sbn_q;
    assign bus.cl_tich  = tich_q;
    assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: random clients and a behavioural multiplier
// checked against a request-level round-robin model.
module tb_mult_share_arbiter;
    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    mult_share_arbiter #(
        .N(N), .NREQ(NREQ), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    bit              act   [NREQ];
    bit              gnt   [NREQ];
    bit              drop  [NREQ];
    bit              rearm [NREQ];
    logic [N-1:0]    sa    [NREQ];
    logic [N-1:0]    sb    [NREQ];
    logic [NREQ-1:0] req_drv;

    int ptr_m, cur, mreq_cyc, rise_cyc, ack_cyc, cyc;
    int acks, mreqs;
    bit infl, rand_on;
    int gq[$];
    int pq[$];

    bit             mul_on, never, fix_lat;
    int             mh, ml, fix_h, fix_l;
    logic [2*N-1:0] prod;

    function automatic int rr_pick(logic [NREQ-1:0] r, int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [N-1:0] pick_op();
        int r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return N'($urandom);
    endfunction

    // multiplier: optional leftover-high hold, low phase, then rise
    task automatic mul_step();
        if (bus.m_req) begin
            mul_on = 1;
            prod   = bus.m_sn * bus.m_sbn;
            if (fix_lat) begin
                mh = fix_h;
                ml = fix_l;
            end else begin
                mh = bus.m_ack ? $urandom_range(0, 2) : 0;
                ml = $urandom_range(1, 4);
            end
        end else if (mul_on) begin
            if (mh > 0) begin
                mh--;
            end else if (ml > 0) begin
                bus.m_ack  = 1'b0;
                bus.m_tich = (2*N)'($urandom);
                ml--;
            end else if (!never) begin
                bus.m_ack  = 1'b1;
                bus.m_tich = prod;
                rise_cyc   = cyc;
                mul_on     = 0;
            end
        end
    endtask

    task automatic observe();
        if (bus.m_req) begin
            int w = rr_pick(req_drv, ptr_m);
            check("single_op", infl, 0);
            check("grant_id", bus.grant_id, w);
            if (w >= 0) begin
                check("m_sn", bus.m_sn, sa[w]);
                check("m_sbn", bus.m_sbn, sb[w]);
                gnt[w] = 1;
            end
            cur      = (w < 0) ? 0 : w;
            infl     = 1;
            mreq_cyc = cyc;
            mreqs++;
        end
        check("busy", bus.busy, infl);
        if (bus.cl_ack != '0) begin
            check("ack_inflight", infl, 1);
            check("cl_ack", bus.cl_ack, 1 << cur);
            if (never) begin
                check("tmo_tich", bus.cl_tich, 0);
                check("tmo_err", bus.cl_err, 1);
                check("tmo_lat", cyc - mreq_cyc, TMO + 1);
            end else begin
                check("cl_tich", bus.cl_tich, sa[cur] * sb[cur]);
                check("cl_err", bus.cl_err, 0);
                check("ack_lat", cyc - rise_cyc, 1);
            end
            gq.push_back(cur);
            pq.push_back(int'(bus.cl_tich));
            acks++;
            ack_cyc    = cyc;
            ptr_m      = (cur + 1) % NREQ;
            act[cur]   = 0;
            gnt[cur]   = 0;
            drop[cur]  = 0;
            infl       = 0;
        end
        if (infl && !never && cyc - mreq_cyc > 200) begin
            check("ack_watchdog", cyc - mreq_cyc, 200);
            infl = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (!act[i]) begin
                if (rearm[i] || (rand_on && $urandom_range(0, 3) == 0)) begin
                    act[i] = 1;
                    sa[i]  = pick_op();
                    sb[i]  = pick_op();
                end
            end else if (rand_on && gnt[i] && !drop[i]
                         && $urandom_range(0, 7) == 0) begin
                drop[i] = 1;
            end
            req_drv[i] = act[i] && !drop[i];
            bus.cl_sn[i*N +: N]  = act[i] ? sa[i] : N'($urandom);
            bus.cl_sbn[i*N +: N] = act[i] ? sb[i] : N'($urandom);
        end
        bus.cl_req = req_drv;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mul_step();
        observe();
        drive();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            act[i]   = 0;
            gnt[i]   = 0;
            drop[i]  = 0;
            rearm[i] = 0;
        end
        req_drv    = '0;
        bus.cl_req = '0;
        infl       = 0;
        ptr_m      = 0;
        acks       = 0;
        mreqs      = 0;
        mul_on     = 0;
        bus.m_ack  = 1'b0;
        never      = 0;
        fix_lat    = 0;
        rand_on    = 0;
        gq.delete();
        pq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_acks(input int target, input int budget);
        int t0 = cyc;
        while (acks < target && cyc - t0 < budget) tick();
        check("acks_reached", acks, target);
    endtask

    initial begin
        bus.cl_req = '0;
        bus.cl_sn  = '0;
        bus.cl_sbn = '0;
        bus.m_tich = '0;
        bus.m_ack  = 1'b0;
        cyc        = 0;
        do_reset();
        check("rst_ack", bus.cl_ack, 0);
        check("rst_tich", bus.cl_tich, 0);
        check("rst_err", bus.cl_err, 0);
        check("rst_mreq", bus.m_req, 0);
        check("rst_msn", bus.m_sn, 0);
        check("rst_msbn", bus.m_sbn, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_gid", bus.grant_id, 0);

        // single channel 12*11
        act[0] = 1; sa[0] = 8'd12; sb[0] = 8'd11;
        run_acks(1, 100);
        repeat (5) tick();
        check("t1_mreqs", mreqs, 1);
        if (gq.size() > 0) check("t1_grant", gq[0], 0);
        if (pq.size() > 0) check("t1_prod", pq[0], 132);
        check("t1_held", bus.cl_tich, 132);

        // all four requesting after reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            act[i] = 1; sa[i] = pick_op(); sb[i] = pick_op();
        end
        sa[1] = 8'd255; sb[1] = 8'd255;
        run_acks(4, 200);
        if (gq.size() == 4)
            for (int k = 0; k < 4; k++) check("t2_order", gq[k], k);
        if (pq.size() == 4) check("t2_ch1", pq[1], 65025);

        // ch0 and ch2 held high
        do_reset();
        act[0] = 1; sa[0] = pick_op(); sb[0] = pick_op();
        act[2] = 1; sa[2] = pick_op(); sb[2] = pick_op();
        rearm[0] = 1; rearm[2] = 1;
        run_acks(6, 300);
        if (gq.size() >= 6)
            for (int k = 0; k < 6; k++) check("t3_order", gq[k], (k % 2) * 2);

        // random traffic
        do_reset();
        rand_on = 1;
        run_acks(1000, 30000);
        rand_on = 0;

        // reset in WAIT
        do_reset();
        fix_lat = 1; fix_h = 0; fix_l = 20;
        act[2] = 1; sa[2] = 8'd3; sb[2] = 8'd4;
        begin
            int t0 = cyc;
            while (!infl && cyc - t0 < 20) tick();
        end
        tick();
        rst = 1'b1;
        clear_model();
        tick();
        rst = 1'b0;
        check("t4_busy", bus.busy, 0);
        check("t4_mreq", bus.m_req, 0);
        check("t4_ack", bus.cl_ack, 0);
        act[1] = 1; sa[1] = 8'd5; sb[1] = 8'd7;
        run_acks(1, 100);
        if (gq.size() > 0) check("t4_grant", gq[0], 1);
        if (pq.size() > 0) check("t4_prod", pq[0], 35);

        // leftover-high m_ack across ISSUE
        do_reset();
        act[3] = 1; sa[3] = 8'd9; sb[3] = 8'd9;
        run_acks(1, 100);
        fix_lat = 1; fix_h = 2; fix_l = 3;
        act[1] = 1; sa[1] = 8'd7; sb[1] = 8'd6;
        run_acks(2, 100);
        repeat (10) tick();
        check("t5_acks", acks, 2);
        if (pq.size() == 2) check("t5_prod", pq[1], 42);
        check("t5_lat", ack_cyc - mreq_cyc, 7);

        // multiplier never answers
        do_reset();
        never = 1;
        act[0] = 1; sa[0] = 8'd2; sb[0] = 8'd3;
`ifdef MARB_TIMEOUT_EN
        run_acks(1, 100);
        if (pq.size() > 0) check("t6_prod", pq[0], 0);
`else
        repeat (100) tick();
        check("t6_noack", acks, 0);
        check("t6_busy", bus.busy, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
